// File: rtl/bus_master_6502_if.sv
// Command, response and 6502-style bus signals of bus_master_6502.
// The master modport is the initiator's view; slave is the side that drives commands and db_i.
interface bus_master_6502_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] rsp_addr;
  logic [15:0] ab;
  logic        rw;
  logic [7:0]  db_o;
  logic [7:0]  db_i;
  logic        clk2out;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, db_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, ab, rw, db_o, clk2out
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, db_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, ab, rw, db_o, clk2out
  );
endinterface

// File: rtl/bus_master_6502.sv
// Cycle-accurate 6502-style bus initiator: phi1/phi2 phases of HALF eclk each,
// commands accepted on the last eclk of phi2, read data returned one eclk after that edge.
module bus_master_6502 #(
  parameter int unsigned HALF = 4
) (
  input  logic               eclk,
  input  logic               ereset,
  bus_master_6502_if.master  bus,
  output logic [31:0]        bus_cycles
);

  typedef enum logic {PHI1, PHI2} phase_t;

  localparam logic [7:0] LAST = 8'(HALF - 1);

  phase_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        boundary;

  logic [15:0] ab_reg;
  logic        rw_reg;
  logic [7:0]  db_o_reg;
  logic        pending_reg;
  logic        rsp_valid_reg;
  logic [7:0]  rsp_data_reg;
  logic [15:0] rsp_addr_reg;
  logic [31:0] bus_cycles_reg;

  always_ff @(posedge eclk) begin
    if (ereset) begin
      state_reg <= PHI1;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // boundary marks the last eclk of phi2, where one bus cycle hands over to the next
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 8'd1;
    boundary   = 1'b0;
    if (cnt_reg == LAST) begin
      cnt_next   = 8'd0;
      state_next = (state_reg == PHI1) ? PHI2 : PHI1;
      boundary   = (state_reg == PHI2);
    end
  end

  always_ff @(posedge eclk) begin
    if (ereset) begin
      ab_reg         <= 16'h0000;
      rw_reg         <= 1'b1;
      db_o_reg       <= 8'h00;
      pending_reg    <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= 8'h00;
      rsp_addr_reg   <= 16'h0000;
      bus_cycles_reg <= 32'd0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (boundary) begin
        bus_cycles_reg <= bus_cycles_reg + 32'd1;
        if (pending_reg) begin
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= bus.db_i;
          rsp_addr_reg  <= ab_reg;
        end
        // no command: dummy read that keeps the previous address and data lines
        if (bus.cmd_valid) begin
          ab_reg      <= bus.cmd_addr;
          rw_reg      <= bus.cmd_rw;
          db_o_reg    <= bus.cmd_wdata;
          pending_reg <= bus.cmd_rw;
        end else begin
          rw_reg      <= 1'b1;
          pending_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.cmd_ready = boundary & ~ereset;
  assign bus.ab        = ab_reg;
  assign bus.rw        = rw_reg;
  assign bus.db_o      = db_o_reg;
  assign bus.clk2out   = (state_reg == PHI2);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_addr  = rsp_addr_reg;
  assign bus_cycles    = bus_cycles_reg;

endmodule

// File: doc/bus_master_6502.md
Name: bus_master_6502

Overview:
- Cycle-accurate 6502-style bus initiator: drives ab, rw, db_o and the clk2out phase, and samples db_i.
- Stands in for chip_6502 so ram_6502 and future memory-mapped responders can be verified without the transistor-level netlist.
- Bus transactions come from a valid/ready command port; read data returns on a response port.
- The bus clock runs continuously; cycles with no command are dummy reads.

Parameters:
- HALF, 4, eclk cycles per bus phase (phi1 length = phi2 length = HALF); legal range 1..255.

Ports:
- eclk  in  1  system clock; all logic on rising edge
- ereset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this eclk when cmd_valid is also high
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  16  bus address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-eclk pulse carrying read result
- rsp_data  out  8  read data
- rsp_addr  out  16  address of the read being returned
- ab  out  16  address bus
- rw  out  1  1 = read, 0 = write
- db_o  out  8  write data toward the responder
- db_i  in  8  read data from the responder
- clk2out  out  1  phi2 (high during the data phase)
- bus_cycles  out  32  count of completed bus cycles, wraps at 2^32

Behaviour:
- Reset (synchronous, ereset high at an eclk edge; wins over everything):
  - ab=0x0000, rw=1, db_o=0x00, clk2out=0.
  - rsp_valid=0, rsp_data=0x00, rsp_addr=0x0000, bus_cycles=0.
  - Phase counter=0, state=PHI1, pending-read flag cleared.
  - Reset mid-cycle abandons that cycle: no rsp_valid and no bus_cycles increment for it.
- State machine:
  - Two states, PHI1 (clk2out=0) and PHI2 (clk2out=1).
  - An 8-bit counter runs 0..HALF-1 in each state.
  - On the counter's last value the state toggles and the counter returns to 0.
- Bus cycle = PHI1 followed by PHI2 = 2*HALF eclk.
- Boundary eclk B = last eclk of PHI2. In B:
  - cmd_ready=1; cmd_ready=0 at all other times, including while ereset is high.
  - If cmd_valid is high, the command is accepted. ab/rw/db_o take cmd_addr/cmd_rw/cmd_wdata at the edge ending B; the new values are visible from B+1 (first PHI1 eclk).
  - If cmd_valid is low, the next cycle is a dummy read: ab holds its previous value, rw=1, db_o holds its previous value, and the pending-read flag is cleared.
  - db_i is sampled at the edge ending B. If the current cycle is a commanded read (pending-read flag set), then from B+1: rsp_valid=1 for exactly one eclk, rsp_data=sampled db_i, rsp_addr=ab of the finished cycle.
  - Writes and dummy reads never produce rsp_valid.
  - bus_cycles increments at the edge ending B, for every cycle including dummies.
- ab, rw and db_o are stable for the whole 2*HALF window; db_o is meaningful only when rw=0.
- Latency from acceptance at eclk T:
  - clk2out rises at T+1+HALF.
  - db_i is sampled at the end of T+2*HALF.
  - rsp_valid is high at T+2*HALF+1.
  - HALF=4: response 9 eclk after acceptance.
- Back-to-back:
  - A command held valid across successive boundaries is accepted at each boundary: one bus cycle per 2*HALF eclk, no idle gap.
  - rsp_valid for cycle n and acceptance for cycle n+2 never share an eclk.
- cmd_valid while cmd_ready=0: not accepted; the command must be held stable until accepted.
- HALF=1: clk2out toggles every eclk; cmd_ready is high every second eclk.
- bus_cycles wrap: 0xFFFFFFFF -> 0x00000000, with no other effect.
- After reset: first boundary at eclk 2*HALF-1 (counting from the first post-reset eclk as 0); the first cycle is a dummy read of 0x0000.

Test Plan:
- Reset, then idle 40 eclk with HALF=4 -> clk2out period 8 eclk, ab=0x0000, rw=1, no rsp_valid, bus_cycles=5.
- Write 0x5A to 0x0200, then read 0x0200 (ram_6502 responder) -> write cycle shows rw=0 and db_o=0x5A for 8 eclk; read gives rsp_valid with rsp_data=0x5A, rsp_addr=0x0200, exactly 9 eclk after read acceptance.
- Four back-to-back reads 0x0000-0x0003 held valid -> four accepts 8 eclk apart, four rsp pulses 8 eclk apart, addresses in order.
- cmd_valid raised mid-PHI1 -> cmd_ready stays low until the boundary; the command is accepted there; ab is unchanged before then.
- ereset asserted during PHI2 of a commanded read -> no rsp_valid; all outputs at reset values next eclk; bus_cycles=0.
- HALF=1, bus_cycles preloaded near wrap via long idle run (force) -> clk2out toggles each eclk; bus_cycles rolls 0xFFFFFFFF to 0.
